grid_scanner: RTL and testbench

//  Feeder/sequencer for the 4x4 window checker. Reads the board row by row

---
 rtl/grid_scanner.sv | 152 +++++++++++++++
 tb/tb_grid_scanner.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_scanner.sv
// Row-by-row board scanner that feeds 4-cell slices to the 4x4 window checker.
// It accumulates the checker's win flags and reports them on a start/done handshake.
module grid_scanner #(
  parameter int ROWS       = 6,
  parameter int COLS       = 7,
  parameter int EARLY_EXIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              g_win,
  output logic              o_win,
  output logic              rd_en,
  output logic [2:0]        rd_row,
  input  logic [2*COLS-1:0] rd_data,
  output logic [7:0]        sub_data,
  output logic              check_en,
  output logic              sub_rst,
  input  logic              chk_g,
  input  logic              chk_o
);

  localparam int NOFF = COLS - 3;
  localparam int CW   = (NOFF > 1) ? $clog2(NOFF) : 1;
  localparam int NSL  = 1 << CW;
  localparam logic [2:0]    R_LAST = 3'(ROWS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 4);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RD, S_PUSH, S_CHK, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic          g_q, g_d;
  logic          o_q, o_d;
  logic          window_full;
  logic          hit;

  // Slice table padded to a power of two so the offset mux never reads past the row.
  logic [7:0] slice [NSL];

  genvar gi;
  generate
    for (gi = 0; gi < NSL; gi++) begin : g_slice
      if (gi < NOFF) begin : g_real
        assign slice[gi] = rd_data[2*gi +: 8];
      end else begin : g_pad
        assign slice[gi] = 8'h00;
      end
    end
  endgenerate

  // The checker only holds four real rows once row 3 has been shifted in.
  assign window_full = (r_q >= 3'd3);
  assign hit         = window_full & (chk_g | chk_o);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      g_q     <= 1'b0;
      o_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      g_q     <= g_d;
      o_q     <= o_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_CLR;
      S_CLR:  state_d = S_RD;
      S_RD:   state_d = S_PUSH;
      S_PUSH: state_d = S_CHK;
      S_CHK: begin
        if ((EARLY_EXIT != 0) && hit) state_d = S_DONE;
        else if (r_q < R_LAST)        state_d = S_RD;
        else if (c_q < C_LAST)        state_d = S_CLR;
        else                          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    r_d = r_q;
    c_d = c_q;
    g_d = g_q;
    o_d = o_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          c_d = '0;
          g_d = 1'b0;
          o_d = 1'b0;
        end
      end
      S_CLR: r_d = '0;
      S_CHK: begin
        if (window_full) begin
          g_d = g_q | chk_g;
          o_d = o_q | chk_o;
        end
        if (r_q < R_LAST)      r_d = r_q + 3'd1;
        else if (c_q < C_LAST) c_d = c_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    rd_en    = 1'b0;
    check_en = 1'b0;
    sub_rst  = 1'b0;
    sub_data = 8'h00;
    case (state_q)
      S_CLR: begin
        busy    = 1'b1;
        sub_rst = 1'b1;
      end
      S_RD: begin
        busy  = 1'b1;
        rd_en = 1'b1;
      end
      S_PUSH: begin
        busy     = 1'b1;
        check_en = 1'b1;
        sub_data = slice[c_q];
      end
      S_CHK:  busy = 1'b1;
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign rd_row = r_q;
  assign g_win  = g_q;
  assign o_win  = o_q;

endmodule

// File: tb/tb_grid_scanner.sv
// Bench for grid_scanner: two instances (full scan and early exit) share one board,
// each with its own read port and 4x4 checker stub, checked against a board-level model.
module tb_grid_scanner;

  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int NOFF = COLS - 3;
  localparam int SPAN = 1 + 3 * ROWS;
  localparam int FULL = 1 + NOFF * SPAN;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  always #5 clk = ~clk;

  logic [2*COLS-1:0] board [ROWS];

  logic              busy_w     [2];
  logic              done_w     [2];
  logic              g_w        [2];
  logic              o_w        [2];
  logic              rd_en_w    [2];
  logic              check_en_w [2];
  logic              sub_rst_w  [2];
  logic              chk_g_w    [2];
  logic              chk_o_w    [2];
  logic [2:0]        rd_row_w   [2];
  logic [7:0]        sub_data_w [2];
  logic [2*COLS-1:0] rd_data_q  [2];
  logic [7:0]        win_q      [2][4];

  int n_checks = 0;
  int n_errors = 0;
  int n_done [2];

  task automatic check(input int id, input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s (dut%0d): got %0d expected %0d", name, id, act, exp);
    end
  endtask

  // True if the 4x4 block (rows w0..w3) holds four in a line of bit b (0=G, 1=O).
  function automatic logic win4(input logic [7:0] w0, input logic [7:0] w1,
                                input logic [7:0] w2, input logic [7:0] w3, input int b);
    logic [7:0] w [4];
    logic found;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    found = 1'b0;
    for (int k = 0; k < 4; k++)
      if (w[k][b] & w[k][2+b] & w[k][4+b] & w[k][6+b]) found = 1'b1;
    for (int j = 0; j < 4; j++)
      if (w[0][2*j+b] & w[1][2*j+b] & w[2][2*j+b] & w[3][2*j+b]) found = 1'b1;
    if (w[0][b] & w[1][2+b] & w[2][4+b] & w[3][6+b]) found = 1'b1;
    if (w[0][6+b] & w[1][4+b] & w[2][2+b] & w[3][b]) found = 1'b1;
    return found;
  endfunction

  function automatic logic [7:0] slice_of(input int r, input int c);
    logic [2*COLS-1:0] row;
    row = board[r];
    return row[2*c +: 8];
  endfunction

  // Scan-level prediction: result flags, done latency and how many reads/clears happen.
  task automatic predict(input int ee, output int lat, output logic g, output logic o,
                         output int nrd, output int nsr);
    logic wg, wo, stopped;
    lat = FULL; g = 1'b0; o = 1'b0; nrd = NOFF * ROWS; nsr = NOFF; stopped = 1'b0;
    for (int c = 0; c < NOFF; c++) begin
      for (int r = 3; r < ROWS; r++) begin
        wg = win4(slice_of(r-3, c), slice_of(r-2, c), slice_of(r-1, c), slice_of(r, c), 0);
        wo = win4(slice_of(r-3, c), slice_of(r-2, c), slice_of(r-1, c), slice_of(r, c), 1);
        if (!stopped) begin
          g = g | wg;
          o = o | wo;
          if ((ee != 0) && (wg | wo)) begin
            stopped = 1'b1;
            lat = 1 + c * SPAN + 3 * r + 4;
            nrd = c * ROWS + r + 1;
            nsr = c + 1;
          end
        end
      end
    end
  endtask

  // Board storage read ports and checker stubs for both instances.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_en_w[i]) rd_data_q[i] <= board[rd_row_w[i]];
      if (!rst_n || sub_rst_w[i]) begin
        for (int k = 0; k < 4; k++) win_q[i][k] <= 8'h00;
      end else if (check_en_w[i]) begin
        win_q[i][0] <= sub_data_w[i];
        win_q[i][1] <= win_q[i][0];
        win_q[i][2] <= win_q[i][1];
        win_q[i][3] <= win_q[i][2];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) if (done_w[i]) n_done[i]++;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      grid_scanner #(.ROWS(ROWS), .COLS(COLS), .EARLY_EXIT(gi)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy_w[gi]),
        .done     (done_w[gi]),
        .g_win    (g_w[gi]),
        .o_win    (o_w[gi]),
        .rd_en    (rd_en_w[gi]),
        .rd_row   (rd_row_w[gi]),
        .rd_data  (rd_data_q[gi]),
        .sub_data (sub_data_w[gi]),
        .check_en (check_en_w[gi]),
        .sub_rst  (sub_rst_w[gi]),
        .chk_g    (chk_g_w[gi]),
        .chk_o    (chk_o_w[gi])
      );

      assign chk_g_w[gi] = win4(win_q[gi][0], win_q[gi][1], win_q[gi][2], win_q[gi][3], 0);
      assign chk_o_w[gi] = win4(win_q[gi][0], win_q[gi][1], win_q[gi][2], win_q[gi][3], 1);

      // Compare this cycle against the model, then advance the model with the inputs
      // that the next rising edge will sample.
      always @(negedge clk) begin : p_model
        static logic act = 1'b0;
        static logic in_rst = 1'b0;
        static logic eg = 1'b0;
        static logic eo = 1'b0;
        static int cyc = 0, lat = 0, nrd = 0, nsr = 0, krd = 0, kck = 0, ksr = 0;
        logic exp_busy, exp_done;
        exp_busy = act && (cyc < lat);
        exp_done = act && (cyc == lat);
        check(gi, "busy", int'(busy_w[gi]), int'(exp_busy));
        check(gi, "done", int'(done_w[gi]), int'(exp_done));
        if (!act || exp_done) begin
          check(gi, "g_win", int'(g_w[gi]), int'(eg));
          check(gi, "o_win", int'(o_w[gi]), int'(eo));
        end
        check(gi, "en_rst_overlap", int'(check_en_w[gi] & sub_rst_w[gi]), 0);
        if (!exp_busy) begin
          check(gi, "idle_rd_en", int'(rd_en_w[gi]), 0);
          check(gi, "idle_check_en", int'(check_en_w[gi]), 0);
          check(gi, "idle_sub_rst", int'(sub_rst_w[gi]), 0);
        end
        if (check_en_w[gi]) begin
          check(gi, "sub_data", int'(sub_data_w[gi]),
                int'(slice_of(kck % ROWS, (kck / ROWS) % NOFF)));
          kck++;
        end else begin
          check(gi, "sub_data_zero", int'(sub_data_w[gi]), 0);
        end
        if (rd_en_w[gi]) begin
          check(gi, "rd_row", int'(rd_row_w[gi]), krd % ROWS);
          krd++;
        end
        if (sub_rst_w[gi]) ksr++;
        if (exp_done) begin
          check(gi, "n_rd", krd, nrd);
          check(gi, "n_check_en", kck, nrd);
          check(gi, "n_sub_rst", ksr, nsr);
        end
        if (in_rst) check(gi, "reset_rd_row", int'(rd_row_w[gi]), 0);

        if (!rst_n) begin
          act = 1'b0; eg = 1'b0; eo = 1'b0; in_rst = 1'b1;
        end else begin
          in_rst = 1'b0;
          if (act) begin
            if (cyc == lat) act = 1'b0;
            else cyc++;
          end else if (start) begin
            act = 1'b1; cyc = 1; krd = 0; kck = 0; ksr = 0;
            predict(gi, lat, eg, eo, nrd, nsr);
          end
        end
      end
    end
  endgenerate

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_board();
    for (int r = 0; r < ROWS; r++) board[r] = '0;
  endtask

  // Pulses start, then follows both instances until each has signalled done.
  task automatic run_scan(output int d0, output int d1, output int nsr0, output int nck0,
                          output int nbusy0, output int nrd1_late);
    int cyc;
    d0 = -1; d1 = -1; nsr0 = 0; nck0 = 0; nbusy0 = 0; nrd1_late = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cyc = 1;
    while ((d0 < 0 || d1 < 0) && cyc < 300) begin
      @(negedge clk);
      if (sub_rst_w[0])  nsr0++;
      if (check_en_w[0]) nck0++;
      if (busy_w[0])     nbusy0++;
      if (d1 >= 0 && rd_en_w[1]) nrd1_late++;
      if (done_w[0] && d0 < 0) d0 = cyc;
      if (done_w[1] && d1 < 0) d1 = cyc;
      @(posedge clk);
      #1;
      cyc++;
    end
    $display("scan: dut0 done@%0d g=%0d o=%0d | dut1 done@%0d g=%0d o=%0d",
             d0, g_w[0], o_w[0], d1, g_w[1], o_w[1]);
  endtask

  initial begin
    int d0, d1, nsr0, nck0, nbusy0, nrd1, dcount;
    n_done[0] = 0;
    n_done[1] = 0;
    clear_board();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < 2; i++) begin
      check(i, "reset_busy", int'(busy_w[i]), 0);
      check(i, "reset_g_win", int'(g_w[i]), 0);
      check(i, "reset_rd_row", int'(rd_row_w[i]), 0);
    end

    // Empty board: full-length scan in both instances.
    run_scan(d0, d1, nsr0, nck0, nbusy0, nrd1);
    check(0, "t1_done_cycle", d0, 77);
    check(0, "t1_busy_cycles", nbusy0, 76);
    check(1, "t1_done_cycle", d1, 77);
    check(0, "t1_g_win", int'(g_w[0]), 0);
    tick(2);

    // G along row 0, columns 3..6; the early-exit copy stops at offset 3, row 3.
    clear_board();
    board[0] = 14'h1540;
    run_scan(d0, d1, nsr0, nck0, nbusy0, nrd1);
    check(0, "t2_g_win", int'(g_w[0]), 1);
    check(0, "t2_o_win", int'(o_w[0]), 0);
    check(0, "t2_done_cycle", d0, 77);
    check(1, "t5_done_cycle", d1, 71);
    check(1, "t5_g_win", int'(g_w[1]), 1);
    check(1, "t5_late_rd_en", nrd1, 0);
    tick(2);

    // O up column 0, rows 2..5.
    clear_board();
    for (int r = 2; r < 6; r++) board[r] = 14'h0002;
    run_scan(d0, d1, nsr0, nck0, nbusy0, nrd1);
    check(0, "t3_o_win", int'(o_w[0]), 1);
    check(0, "t3_g_win", int'(g_w[0]), 0);
    check(0, "t3_sub_rst_pulses", nsr0, 4);
    check(0, "t3_check_en_pulses", nck0, 24);
    check(1, "t3_ee_done_cycle", d1, 20);
    tick(2);

    // G diagonal (0,1)..(3,4).
    clear_board();
    board[0] = 14'h0004; board[1] = 14'h0010; board[2] = 14'h0040; board[3] = 14'h0100;
    run_scan(d0, d1, nsr0, nck0, nbusy0, nrd1);
    check(0, "t4_diag_g_win", int'(g_w[0]), 1);
    check(0, "t4_diag_o_win", int'(o_w[0]), 0);
    check(1, "t4_diag_ee_done", d1, 33);
    tick(2);

    // G anti-diagonal (0,6),(1,5),(2,4),(3,3).
    clear_board();
    board[0] = 14'h1000; board[1] = 14'h0400; board[2] = 14'h0100; board[3] = 14'h0040;
    run_scan(d0, d1, nsr0, nck0, nbusy0, nrd1);
    check(0, "t4_anti_g_win", int'(g_w[0]), 1);
    check(1, "t4_anti_ee_done", d1, 71);
    tick(2);

    // Illegal board holding both a G row and an O column.
    clear_board();
    for (int r = 2; r < 6; r++) board[r] = 14'h0002;
    board[0] = 14'h1540;
    run_scan(d0, d1, nsr0, nck0, nbusy0, nrd1);
    check(0, "both_g_win", int'(g_w[0]), 1);
    check(0, "both_o_win", int'(o_w[0]), 1);
    check(1, "both_ee_g_win", int'(g_w[1]), 0);
    check(1, "both_ee_o_win", int'(o_w[1]), 1);
    tick(2);

    // Restart attempt mid-scan, then reset at edge 30 after the start edge.
    clear_board();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(10);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(18);
    dcount = n_done[0];
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check(0, "t6_rst_busy", int'(busy_w[0]), 0);
    check(0, "t6_rst_done", int'(done_w[0]), 0);
    check(0, "t6_rst_rd_en", int'(rd_en_w[0]), 0);
    check(0, "t6_rst_check_en", int'(check_en_w[0]), 0);
    check(0, "t6_rst_sub_rst", int'(sub_rst_w[0]), 0);
    check(0, "t6_rst_sub_data", int'(sub_data_w[0]), 0);
    check(0, "t6_rst_rd_row", int'(rd_row_w[0]), 0);
    check(0, "t6_no_done", n_done[0] - dcount, 0);
    tick(1);
    run_scan(d0, d1, nsr0, nck0, nbusy0, nrd1);
    check(0, "t6_rescan_done_cycle", d0, 77);
    check(0, "t6_rescan_g_win", int'(g_w[0]), 0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
